// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes and the FSM states.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges sub-word store data into a word and extracts/extends
// load data from a word, little-endian lane order.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [NUM_LANES-1:0] be;
  logic [31:0]          sdata;
  logic [31:0]          shifted;

  // Replicate the store data across lanes so each enabled lane just picks it up.
  always_comb begin
    be    = '1;
    sdata = wdata;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << offset;
        sdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign merged[LANE_W*i +: LANE_W] = be[i] ? sdata[LANE_W*i +: LANE_W]
                                              : word[LANE_W*i +: LANE_W];
  end

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    extracted = shifted;
    case (size)
      SZ_BYTE: extracted = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
      SZ_HALF: extracted = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit with read-modify-write for sub-word stores.
// Define MEM_ACCESS_RANGE_CHECK_EN to fault accesses at or beyond MEM_WORDS.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_e      state, state_nx;
  size_e       req_sz, size_q;
  logic        we_q, uns_q, err_q, fault;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [31:0] align_word, merged, extracted;

  assign req_sz = size_e'(req_size);

  always_comb begin
    case (req_sz)
      SZ_HALF: fault = req_addr[0];
      SZ_WORD: fault = |req_addr[1:0];
      SZ_ILL:  fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if (RANGE_CHECK && (req_addr[31:2] >= MEM_LIMIT)) fault = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Word stores skip the read; sub-word stores read first so other lanes survive.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid)
                 state_nx = fault ? RESP : (req_we && req_sz == SZ_WORD) ? WRITE : READ;
      READ:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          size_q  <= req_sz;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          err_q   <= fault;
          rdata_q <= '0;
        end
        READ: begin
          word_q <= mem_rdata;
          if (!we_q) rdata_q <= extracted;
        end
        default: ;
      endcase
    end
  end

  // Extraction works on the live read word; merging on the captured one.
  assign align_word = (state == READ) ? mem_rdata : word_q;

  mem_lane_align u_align (
    .word        (align_word),
    .wdata       (wdata_q),
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .merged      (merged),
    .extracted   (extracted)
  );

  assign req_ready  = (state == IDLE);
  assign mem_read   = (state == READ);
  assign mem_write  = (state == WRITE);
  assign mem_addr   = (state == READ || state == WRITE) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata  = (state == WRITE) ? merged : '0;
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) ? err_q : 1'b0;
  assign resp_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small combinational-read word memory.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:63];
  int          wr_cnt, rd_cnt, both_cnt;
  logic [31:0] last_raddr, last_wdata;
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  int total, bad;

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index wraps modulo 64 words through the 6-bit slice.
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= mem_wdata;
    end
    if (mem_read) begin
      rd_cnt     <= rd_cnt + 1;
      last_raddr <= mem_addr;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Issues one request, measures edges from acceptance to resp_valid, then accepts.
  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      req_valid = 1'b0;
    end while (!resp_valid && lat < 12);
    chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, w0, r0;
    logic [31:0] rd, hold;
    logic        e;

    total = 0; bad = 0;
    wr_cnt = 0; rd_cnt = 0; both_cnt = 0;
    last_raddr = '0; last_wdata = '0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    #12;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    poke(6'd4, 32'h11223344);
    run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, e);
    chk("lb13_data", rd, 32'h00000011);
    chk("lb13_lat", 32'(lat), 32'd2);
    chk("lb13_err", {31'b0, e}, 32'd0);
    chk("lb13_raddr", last_raddr, 32'h10);

    poke(6'd4, 32'h80001234);
    run(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, e);
    chk("lh12_data", rd, 32'hFFFF8000);
    chk("lh12_lat", 32'(lat), 32'd2);
    run(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, e);
    chk("lhu12_data", rd, 32'h00008000);
    run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, e);
    chk("lbu13_data", rd, 32'h00000080);
    run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, e);
    chk("lb13s_data", rd, 32'hFFFFFF80);
    run(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, e);
    chk("lb11_data", rd, 32'h00000012);
    run(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, rd, e);
    chk("lw10_data", rd, 32'h80001234);

    poke(6'd4, 32'h11223344);
    w0 = wr_cnt;
    run(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, lat, rd, e);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sb_wdata", last_wdata, 32'h1122AB44);
    chk("sb_mem", mem[4], 32'h1122AB44);
    chk("sb_rdata", rd, 32'd0);
    chk("sb_err", {31'b0, e}, 32'd0);

    poke(6'd5, 32'h55667788);
    run(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFFBEEF, lat, rd, e);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_mem", mem[5], 32'hBEEF7788);

    w0 = wr_cnt; r0 = rd_cnt;
    run(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D, lat, rd, e);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_mem", mem[6], 32'hCAFEF00D);
    chk("sw_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sw_reads", 32'(rd_cnt - r0), 32'd0);

    w0 = wr_cnt; r0 = rd_cnt;
    run(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, lat, rd, e);
    chk("swmis_err", {31'b0, e}, 32'd1);
    chk("swmis_lat", 32'(lat), 32'd1);
    chk("swmis_rdata", rd, 32'd0);
    chk("swmis_access", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    run(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, e);
    chk("ill_err", {31'b0, e}, 32'd1);
    chk("ill_lat", 32'(lat), 32'd1);
    run(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rd, e);
    chk("lhmis_err", {31'b0, e}, 32'd1);
    chk("mis_no_access", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

    poke(6'd0, 32'hA5A50F0F);
    run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, e);
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    chk("oor_err", {31'b0, e}, 32'd1);
    chk("oor_lat", 32'(lat), 32'd1);
`else
    chk("oor_err", {31'b0, e}, 32'd0);
    chk("oor_data", rd, 32'hA5A50F0F);
    chk("oor_raddr", last_raddr, 32'h100);
`endif

    // Response backpressure: lw of word 4 (0x1122AB44) held for five cycles.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_first_valid", {31'b0, resp_valid}, 32'd1);
    hold = resp_rdata;
    chk("bp_first_data", hold, 32'h1122AB44);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_data", resp_rdata, 32'h1122AB44);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_idle_rdata", resp_rdata, 32'd0);

    // Reset while an sh is in its read cycle.
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h00001234;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("abort_in_read", {31'b0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rw", {30'b0, mem_read, mem_write}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    chk("abort_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("abort_mem", mem[5], 32'hBEEF7788);
    run(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rd, e);
    chk("post_rst_lw", rd, 32'hBEEF7788);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_err", {31'b0, e}, 32'd0);

    chk("rw_overlap", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 64, depth in 32-bit words of the attached data memory.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  CPU access request present.
REQ-005 Port: req_ready  output  1  unit can accept a request.
REQ-006 Port: req_we  input  1  1=store, 0=load.
REQ-007 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 Port: req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-justified.
REQ-011 Port: resp_valid  output  1  response present; held until accepted.
REQ-012 Port: resp_ready  input  1  CPU accepts response.
REQ-013 Port: resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 Port: resp_err  output  1  misaligned, illegal-size or out-of-range access.
REQ-015 Port: mem_read  output  1  read enable to the data memory.
REQ-016 Port: mem_write  output  1  write enable to the data memory.
REQ-017 Port: mem_addr  output  32  word-aligned byte address, bits [1:0]=00.
REQ-018 Port: mem_wdata  output  32  full word to write.
REQ-019 Port: mem_rdata  input  32  combinational read word from the data memory.

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on the cycle req_valid&req_ready; all request fields SHALL be registered at acceptance.
REQ-022 IDLE SHALL transition to: RESP with err=1 on a fault; WRITE for a word store; READ for a load or a sub-word store.
REQ-023 A fault SHALL be: size 11; half with addr[0]=1; word with addr[1:0]!=00. A faulting request SHALL cause no mem_read or mem_write.
REQ-024 READ SHALL last exactly 1 cycle with mem_read=1 and SHALL capture mem_rdata at the cycle end; it SHALL then go to RESP for a load or WRITE for a store.
REQ-025 WRITE SHALL last exactly 1 cycle with mem_write=1; mem_addr and mem_wdata SHALL be stable for the whole cycle.
REQ-026 Sub-word store merge SHALL replace only the addressed byte (addr[1:0]) or half (addr[1]) of the captured word, little-endian lane order; bits of other lanes SHALL be unchanged.
REQ-027 Load extraction SHALL select the addressed lane and extend it to 32 bits per req_unsigned; word loads SHALL ignore req_unsigned.
REQ-028 RESP SHALL hold resp_valid=1 and stable data until resp_ready=1, then return to IDLE; the next request SHALL be accepted no earlier than the following cycle.
REQ-029 Acceptance-to-resp_valid latency SHALL be: fault 1; word store 2; load 2; sub-word store 3.
REQ-030 mem_read and mem_write SHALL never both be 1; both SHALL be 0 outside READ and WRITE.
REQ-031 mem_addr SHALL equal {addr[31:2],2'b00} in READ and WRITE and 0 otherwise.

Reset
REQ-032 Reset assertion SHALL force IDLE asynchronously and set resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr and mem_wdata to 0, aborting any in-flight access with no write issued.
REQ-033 After release, req_ready SHALL be 1 at the first clock edge.

Configuration
REQ-034 With MEM_ACCESS_RANGE_CHECK_EN defined, addr[31:2] >= MEM_WORDS SHALL be a fault (REQ-023 rules apply).
REQ-035 Without MEM_ACCESS_RANGE_CHECK_EN, out-of-range addresses SHALL be passed through unchanged, and the index SHALL wrap modulo MEM_WORDS inside the memory.

Structure
REQ-036 Package mem_access_pkg SHALL hold the size encodings and the FSM state enum.
REQ-037 Lane merge and extract logic SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-038 Bench scenario: memory word 4 = 0x11223344; lb addr 0x13, signed -> resp_rdata 0x00000011 after 2 cycles; lh addr 0x12, signed, with word 0x8000xxxx -> resp_rdata 0xFFFF8000.
REQ-039 Bench scenario: sb 0xAB to addr 0x11 with word 0x11223344 -> exactly one mem_write, mem_wdata 0x1122AB44, resp_valid after 3 cycles.
REQ-040 Bench scenario: sw addr 0x06 -> resp_err=1 after 1 cycle, with no mem_read or mem_write.
REQ-041 Bench scenario: with the macro defined, lw addr 0x100 and MEM_WORDS=64 -> resp_err=1; without the macro -> normal load with mem_addr 0x100.
REQ-042 Bench scenario: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable and req_ready=0 throughout.
REQ-043 Bench scenario: rst_n asserted during READ of an sh -> all outputs 0 immediately and no write occurs; a new lw after release completes normally.
